// File: rtl/axi_wdata_if.sv
// W-channel allocator bundle: AW-side ID push, initiator W channels, target W channel.
// The slave modport is the allocator's view of the bundle.
interface axi_wdata_if #(
    parameter int unsigned N_TARG_PORT = 4,
    parameter int unsigned FIFO_DEPTH  = 8
);
    localparam int unsigned SEL_W = $clog2(N_TARG_PORT);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                   push_ID_i;
    logic [N_TARG_PORT-1:0] ID_i;
    logic                   grant_FIFO_ID_o;
    logic [N_TARG_PORT-1:0] wvalid_i;
    logic [N_TARG_PORT-1:0] wlast_i;
    logic [N_TARG_PORT-1:0] wready_o;
    logic                   wvalid_o;
    logic                   wlast_o;
    logic                   wready_i;
    logic [SEL_W-1:0]       wsel_o;
    logic [CNT_W-1:0]       occupancy_o;
    logic                   err_onehot_o;

    modport slave (
        input  push_ID_i, ID_i, wvalid_i, wlast_i, wready_i,
        output grant_FIFO_ID_o, wready_o, wvalid_o, wlast_o, wsel_o,
               occupancy_o, err_onehot_o
    );

    modport master (
        output push_ID_i, ID_i, wvalid_i, wlast_i, wready_i,
        input  grant_FIFO_ID_o, wready_o, wvalid_o, wlast_o, wsel_o,
               occupancy_o, err_onehot_o
    );
endinterface

// File: rtl/axi_wdata_allocator.sv
// Grants the shared target W channel to initiators in AW-grant order, holding each
// grant until its WLAST beat completes. IDs are queued in a small circular buffer.
module axi_wdata_allocator #(
    parameter int unsigned N_TARG_PORT = 4,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         test_en_i,
    axi_wdata_if.slave   bus
);
    localparam int unsigned SEL_W = $clog2(N_TARG_PORT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [N_TARG_PORT-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SEL_W-1:0]       wsel_q;
    logic                   err_q;

    logic [N_TARG_PORT-1:0] head;
    logic [SEL_W-1:0]       head_idx;
    logic                   id_onehot;
    logic                   full;
    logic                   push_ok;
    logic                   pop;

    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // Head decode: one-hot queue entry to binary mux select
    always_comb begin
        head     = mem[rd_ptr_q];
        head_idx = '0;
        for (int i = 0; i < int'(N_TARG_PORT); i++) begin
            if (head[i]) head_idx = head_idx | SEL_W'(i);
        end
    end

    // Next-state, queue bookkeeping and W steering
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        bus.wvalid_o = 1'b0;
        bus.wlast_o  = 1'b0;
        bus.wready_o = '0;
        bus.wsel_o   = wsel_q;

        full      = (count_q == CNT_W'(FIFO_DEPTH));
        id_onehot = (bus.ID_i != '0) && ((bus.ID_i & (bus.ID_i - 1'b1)) == '0);
        push_ok   = bus.push_ID_i && !full && id_onehot;

        if (state_q == BURST) begin
            bus.wvalid_o = bus.wvalid_i[head_idx];
            bus.wlast_o  = bus.wlast_i[head_idx];
            bus.wready_o = {N_TARG_PORT{bus.wready_i}} & head;
            bus.wsel_o   = head_idx;
        end
        pop = (state_q == BURST) && bus.wvalid_o && bus.wready_i && bus.wlast_o;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (count_d != '0) state_d = BURST;
            BURST:   if (pop && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant_FIFO_ID_o = !full;
    assign bus.occupancy_o     = count_q;
    assign bus.err_onehot_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wsel_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= bus.push_ID_i && !id_onehot;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (state_q == BURST) wsel_q <= head_idx;
        end
    end

    // ID storage needs no reset: entries are only read once counted valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.ID_i;
    end
endmodule

// File: tb/tb_axi_wdata_allocator.sv
// Directed and scoreboard-driven bench for axi_wdata_allocator.
module tb_axi_wdata_allocator;
    logic clk;
    logic rst_n;
    logic test_en_i;
    int   checks;
    int   errors;

    axi_wdata_if #(.N_TARG_PORT(4), .FIFO_DEPTH(8)) bus ();

    axi_wdata_allocator #(.N_TARG_PORT(4), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_en_i (test_en_i),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id);
        bus.push_ID_i = 1'b1;
        bus.ID_i      = id;
        step();
        bus.push_ID_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wvalid_i = 4'b1111;
        bus.wready_i = 1'b1;
        #12;
        checks++; if (bus.wvalid_o !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", bus.wvalid_o); end
        checks++; if (bus.wready_o !== 4'b0000) begin errors++; $display("FAIL reset_wready got=%b exp=0000", bus.wready_o); end
        checks++; if (bus.grant_FIFO_ID_o !== 1'b1) begin errors++; $display("FAIL reset_grant got=%b exp=1", bus.grant_FIFO_ID_o); end
        checks++; if (bus.occupancy_o !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy_o); end
        checks++; if (bus.err_onehot_o !== 1'b0 || bus.wsel_o !== 2'd0 || bus.wlast_o !== 1'b0) begin
            errors++; $display("FAIL reset_misc err=%b wsel=%0d wlast=%b exp 0/0/0", bus.err_onehot_o, bus.wsel_o, bus.wlast_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        checks++; if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 4'b0000 || bus.occupancy_o !== 4'd0) begin
            errors++; $display("FAIL idle_after_reset wvalid=%b wready=%b occ=%0d exp 0/0000/0", bus.wvalid_o, bus.wready_o, bus.occupancy_o); end
        bus.wvalid_i = 4'b0000;
    endtask

    task automatic test_ordered_service();
        int b1 = 0;
        int b3 = 0;
        int exp_sel;
        logic exp_last;
        push(4'b0010);
        push(4'b1000);
        checks++; if (bus.occupancy_o !== 4'd2) begin errors++; $display("FAIL order_occ got=%0d exp=2", bus.occupancy_o); end
        bus.wready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.wvalid_i = {b3 < 2, 1'b0, b1 < 3, 1'b0};
            bus.wlast_i  = {b3 == 1, 1'b0, b1 == 2, 1'b0};
            exp_sel  = (b1 < 3) ? 1 : 3;
            exp_last = (b1 < 3) ? (b1 == 2) : (b3 == 1);
            #1;
            checks++;
            if (bus.wvalid_o !== 1'b1 || bus.wsel_o !== 2'(exp_sel) || bus.wlast_o !== exp_last ||
                bus.wready_o !== 4'(1 << exp_sel)) begin
                errors++;
                $display("FAIL order_beat%0d wvalid=%b wsel=%0d wlast=%b wready=%b exp 1/%0d/%b/%b",
                         c, bus.wvalid_o, bus.wsel_o, bus.wlast_o, bus.wready_o, exp_sel, exp_last, 4'(1 << exp_sel));
            end
            step();
            if (b1 < 3) b1++; else b3++;
        end
        bus.wvalid_i = 4'b0000;
        bus.wlast_i  = 4'b0000;
        #1;
        checks++; if (bus.occupancy_o !== 4'd0 || bus.wvalid_o !== 1'b0 || bus.wsel_o !== 2'd3) begin
            errors++; $display("FAIL order_done occ=%0d wvalid=%b wsel=%0d exp 0/0/3", bus.occupancy_o, bus.wvalid_o, bus.wsel_o); end
    endtask

    task automatic test_backpressure();
        push(4'b0100);
        bus.wvalid_i = 4'b0100;
        bus.wlast_i  = 4'b0100;
        bus.wready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.wvalid_o !== 1'b1 || bus.wready_o !== 4'b0000 || bus.occupancy_o !== 4'd1 || bus.wsel_o !== 2'd2) begin
                errors++; $display("FAIL bp_hold%0d wvalid=%b wready=%b occ=%0d wsel=%0d exp 1/0000/1/2",
                                   c, bus.wvalid_o, bus.wready_o, bus.occupancy_o, bus.wsel_o);
            end
            step();
        end
        bus.wready_i = 1'b1;
        #1;
        checks++; if (bus.wready_o !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=0100", bus.wready_o); end
        step();
        checks++; if (bus.occupancy_o !== 4'd0 || bus.wvalid_o !== 1'b0) begin
            errors++; $display("FAIL bp_pop occ=%0d wvalid=%b exp 0/0", bus.occupancy_o, bus.wvalid_o); end
        bus.wvalid_i = 4'b0000;
        bus.wlast_i  = 4'b0000;
    endtask

    task automatic test_full_queue();
        for (int i = 0; i < 8; i++) push(4'(1 << (i % 4)));
        checks++; if (bus.occupancy_o !== 4'd8 || bus.grant_FIFO_ID_o !== 1'b0) begin
            errors++; $display("FAIL full_state occ=%0d grant=%b exp 8/0", bus.occupancy_o, bus.grant_FIFO_ID_o); end
        push(4'b0001);
        checks++; if (bus.occupancy_o !== 4'd8) begin errors++; $display("FAIL full_ninth occ=%0d exp=8", bus.occupancy_o); end
        // pop head (initiator 0) while pushing; the push must be refused
        bus.wvalid_i  = 4'b0001;
        bus.wlast_i   = 4'b0001;
        bus.wready_i  = 1'b1;
        bus.push_ID_i = 1'b1;
        bus.ID_i      = 4'b0010;
        step();
        bus.push_ID_i = 1'b0;
        bus.wvalid_i  = 4'b0000;
        bus.wlast_i   = 4'b0000;
        #1;
        checks++; if (bus.occupancy_o !== 4'd7 || bus.grant_FIFO_ID_o !== 1'b1) begin
            errors++; $display("FAIL full_pushpop occ=%0d grant=%b exp 7/1", bus.occupancy_o, bus.grant_FIFO_ID_o); end
        push(4'b0010);
        checks++; if (bus.occupancy_o !== 4'd8) begin errors++; $display("FAIL full_refill occ=%0d exp=8", bus.occupancy_o); end
        bus.wvalid_i = 4'b1111;
        bus.wlast_i  = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            int es;
            es = (i < 8) ? (i % 4) : 1;
            #1;
            checks++; if (bus.wsel_o !== 2'(es)) begin errors++; $display("FAIL full_drain%0d wsel=%0d exp=%0d", i, bus.wsel_o, es); end
            step();
        end
        bus.wvalid_i = 4'b0000;
        bus.wlast_i  = 4'b0000;
        #1;
        checks++; if (bus.occupancy_o !== 4'd0) begin errors++; $display("FAIL full_empty occ=%0d exp=0", bus.occupancy_o); end
    endtask

    task automatic test_bad_id();
        push(4'b0110);
        checks++; if (bus.err_onehot_o !== 1'b1 || bus.occupancy_o !== 4'd0) begin
            errors++; $display("FAIL badid_flag err=%b occ=%0d exp 1/0", bus.err_onehot_o, bus.occupancy_o); end
        step();
        checks++; if (bus.err_onehot_o !== 1'b0) begin errors++; $display("FAIL badid_pulse err=%b exp=0", bus.err_onehot_o); end
        push(4'b0000);
        checks++; if (bus.err_onehot_o !== 1'b1 || bus.occupancy_o !== 4'd0) begin
            errors++; $display("FAIL badid_zero err=%b occ=%0d exp 1/0", bus.err_onehot_o, bus.occupancy_o); end
        step();
    endtask

    task automatic test_wrap_random();
        int q_id[$];
        int q_len[$];
        int beat = 0;
        int budget;
        for (int batch = 0; batch < 5; batch++) begin
            bus.wvalid_i = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                int r;
                r = int'($urandom_range(0, 3));
                q_id.push_back(r);
                q_len.push_back(int'($urandom_range(1, 4)));
                push(4'(1 << r));
            end
            budget = 0;
            while (q_id.size() > 0 && budget < 400) begin
                logic [3:0] vin;
                logic [3:0] wl;
                logic       rdy;
                logic       last;
                int         h;
                h    = q_id[0];
                last = (beat == q_len[0] - 1);
                vin  = 4'($urandom);
                rdy  = 1'($urandom_range(0, 1));
                wl   = 4'($urandom);
                wl[h] = last;
                bus.wvalid_i = vin;
                bus.wlast_i  = wl;
                bus.wready_i = rdy;
                #1;
                checks++;
                if (bus.wsel_o !== 2'(h) || bus.wvalid_o !== vin[h] || bus.wlast_o !== last ||
                    bus.wready_o !== (rdy ? 4'(1 << h) : 4'b0000) || bus.occupancy_o !== 4'(q_id.size())) begin
                    errors++;
                    $display("FAIL rand_b%0d wsel=%0d wvalid=%b wlast=%b wready=%b occ=%0d exp %0d/%b/%b/%b/%0d",
                             batch, bus.wsel_o, bus.wvalid_o, bus.wlast_o, bus.wready_o, bus.occupancy_o,
                             h, vin[h], last, rdy ? 4'(1 << h) : 4'b0000, q_id.size());
                end
                step();
                if (vin[h] && rdy) begin
                    if (last) begin
                        void'(q_id.pop_front());
                        void'(q_len.pop_front());
                        beat = 0;
                    end else beat++;
                end
                budget++;
            end
            if (q_id.size() > 0) begin
                checks++; errors++;
                $display("FAIL rand_timeout batch=%0d remaining=%0d exp 0", batch, q_id.size());
                q_id.delete();
                q_len.delete();
            end
        end
        bus.wvalid_i = 4'b0000;
        bus.wlast_i  = 4'b0000;
    endtask

    task automatic test_async_reset();
        push(4'b0001);
        bus.wvalid_i = 4'b0001;
        bus.wlast_i  = 4'b0000;
        bus.wready_i = 1'b0;
        #1;
        checks++; if (bus.wvalid_o !== 1'b1) begin errors++; $display("FAIL arst_pre wvalid=%b exp=1", bus.wvalid_o); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.wvalid_o !== 1'b0 || bus.wready_o !== 4'b0000 || bus.wlast_o !== 1'b0 || bus.wsel_o !== 2'd0 ||
            bus.occupancy_o !== 4'd0 || bus.grant_FIFO_ID_o !== 1'b1 || bus.err_onehot_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs wvalid=%b wready=%b wlast=%b wsel=%0d occ=%0d grant=%b err=%b exp 0/0000/0/0/0/1/0",
                     bus.wvalid_o, bus.wready_o, bus.wlast_o, bus.wsel_o, bus.occupancy_o, bus.grant_FIFO_ID_o, bus.err_onehot_o);
        end
        step();
        rst_n = 1'b1;
        bus.wvalid_i = 4'b0000;
        step();
        push(4'b0100);
        bus.wvalid_i = 4'b0100;
        bus.wlast_i  = 4'b0100;
        bus.wready_i = 1'b1;
        #1;
        checks++; if (bus.wsel_o !== 2'd2 || bus.wready_o !== 4'b0100 || bus.wvalid_o !== 1'b1) begin
            errors++; $display("FAIL arst_recover wsel=%0d wready=%b wvalid=%b exp 2/0100/1", bus.wsel_o, bus.wready_o, bus.wvalid_o); end
        step();
        checks++; if (bus.occupancy_o !== 4'd0) begin errors++; $display("FAIL arst_drain occ=%0d exp=0", bus.occupancy_o); end
        bus.wvalid_i = 4'b0000;
        bus.wlast_i  = 4'b0000;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        test_en_i     = 1'b0;
        rst_n         = 1'b0;
        bus.push_ID_i = 1'b0;
        bus.ID_i      = 4'b0000;
        bus.wvalid_i  = 4'b0000;
        bus.wlast_i   = 4'b0000;
        bus.wready_i  = 1'b0;
        test_reset();
        test_ordered_service();
        test_backpressure();
        test_full_queue();
        test_bad_id();
        test_wrap_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
